// File: rtl/instr_fetch_resp_pkg.sv
// Shared constants and types for the instruction-fetch responder.
// The LFSR helpers are only used when INSTR_FETCH_RESP_STALL_EN is defined.
package instr_fetch_resp_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [31:0] addr;
    } resp_beat_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// In-order synchronous FIFO with flush; flush wins over push and pop in the same cycle.
// Pushes while full and pops while empty are ignored.
module instr_fetch_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction-memory slave for the core fetch port: serves queued words in order, NOP when empty.
// Define INSTR_FETCH_RESP_STALL_EN to insert pseudo-random grant wait states from an LFSR.
module instr_fetch_responder
    import instr_fetch_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   push_valid_i,
    input  logic [31:0]            push_data_i,
    output logic                   push_ready_o,
    input  logic                   flush_i,
    input  logic                   instr_req_i,
    input  logic [31:0]            instr_addr_i,
    output logic                   instr_gnt_o,
    output logic                   instr_rvalid_o,
    output logic [31:0]            instr_rdata_o,
    output logic [31:0]            resp_addr_o,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   empty_o,
    output logic [15:0]            nop_count_o
);

    logic        accept;
    logic        use_nop;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    resp_beat_t  beat_in;
    resp_beat_t  line_q [LATENCY];
    logic [15:0] nop_cnt_q, nop_cnt_d;

`ifdef INSTR_FETCH_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_next(lfsr_q);
    end

    assign instr_gnt_o = instr_req_i && !lfsr_q[0];
`else
    assign instr_gnt_o = instr_req_i;
`endif

    assign accept   = instr_req_i && instr_gnt_o;
    // A fetch landing on a flush is answered with a NOP rather than the head being flushed away.
    assign use_nop  = accept && (fifo_empty || flush_i);
    assign fifo_pop = accept && !fifo_empty && !flush_i;

    instr_fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (push_valid_i),
        .push_data_i (push_data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Idle beats are all-zero so rdata/resp_addr read 0 whenever rvalid is low.
    always_comb begin
        beat_in   = '0;
        nop_cnt_d = nop_cnt_q;
        if (accept) begin
            beat_in.valid = 1'b1;
            beat_in.addr  = instr_addr_i;
            beat_in.data  = use_nop ? NOP_INSTR : fifo_rdata;
        end
        if (use_nop && (nop_cnt_q != 16'hFFFF)) nop_cnt_d = nop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
            nop_cnt_q <= '0;
        end else begin
            line_q[0] <= beat_in;
            for (int i = 1; i < LATENCY; i++) line_q[i] <= line_q[i-1];
            nop_cnt_q <= nop_cnt_d;
        end
    end

    assign instr_rvalid_o = line_q[LATENCY-1].valid;
    assign instr_rdata_o  = line_q[LATENCY-1].data;
    assign resp_addr_o    = line_q[LATENCY-1].addr;
    assign push_ready_o   = !fifo_full;
    assign empty_o        = fifo_empty;
    assign nop_count_o    = nop_cnt_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench: one LATENCY=1 responder for queue/flush/NOP behaviour, one LATENCY=3 for latency and reset.
`timescale 1ns/1ps
module tb_instr_fetch_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, push_valid = 1'b0, flush = 1'b0, req = 1'b0;
    logic [31:0] push_data = '0, addr = '0;
    logic        push_ready, gnt, rvalid, empty;
    logic [31:0] rdata, raddr;
    logic [4:0]  count;
    logic [15:0] nop_cnt;

    logic        rst3_n = 1'b0, push_valid3 = 1'b0, flush3 = 1'b0, req3 = 1'b0;
    logic [31:0] push_data3 = '0, addr3 = '0;
    logic        push_ready3, gnt3, rvalid3, empty3;
    logic [31:0] rdata3, raddr3;
    logic [4:0]  count3;
    logic [15:0] nop_cnt3;

    instr_fetch_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut (
        .clk(clk), .rst_ni(rst_n), .push_valid_i(push_valid), .push_data_i(push_data),
        .push_ready_o(push_ready), .flush_i(flush), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .resp_addr_o(raddr),
        .fifo_count_o(count), .empty_o(empty), .nop_count_o(nop_cnt)
    );

    instr_fetch_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_ni(rst3_n), .push_valid_i(push_valid3), .push_data_i(push_data3),
        .push_ready_o(push_ready3), .flush_i(flush3), .instr_req_i(req3), .instr_addr_i(addr3),
        .instr_gnt_o(gnt3), .instr_rvalid_o(rvalid3), .instr_rdata_o(rdata3), .resp_addr_o(raddr3),
        .fifo_count_o(count3), .empty_o(empty3), .nop_count_o(nop_cnt3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    int          cyc = 0;
    logic [31:0] mq[$];
    logic [31:0] mq3[$];
    exp_t        exq[$];
    exp_t        exq3[$];
    int unsigned nop_m = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    exp_t        e1, e3;
    logic [31:0] w1;
    bit          rdy1;

    always @(posedge clk) cyc++;

    // Reference model of the LATENCY=1 responder, evaluated mid-cycle for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            exq.delete();
            nop_m  = 0;
            lfsr_m = 16'hACE1;
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_raddr", raddr, 0);
            chk("rst_nop_cnt", nop_cnt, 0);
            chk("rst_ready", push_ready, 1);
            chk("rst_empty", empty, 1);
            chk("rst_count", count, 0);
            chk("rst_gnt", gnt, 0);
        end else begin
            if (rvalid) begin
                if (exq.size() == 0) chk("spurious_rvalid", 1, 0);
                else begin
                    e1 = exq.pop_front();
                    chk("rdata", rdata, e1.data);
                    chk("resp_addr", raddr, e1.addr);
                    chk("latency", cyc, e1.due);
                end
            end else begin
                chk("idle_data_addr", {rdata, raddr}, 64'd0);
                if (exq.size() > 0 && exq[0].due <= cyc) begin
                    chk("missing_rvalid", 0, 1);
                    void'(exq.pop_front());
                end
            end
            chk("count", count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("push_ready", push_ready, mq.size() < DEPTH);
            chk("nop_count", nop_cnt, nop_m);
`ifdef INSTR_FETCH_RESP_STALL_EN
            chk("gnt", gnt, req && !lfsr_m[0]);
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`else
            chk("gnt", gnt, req);
`endif
            rdy1 = mq.size() < DEPTH;
            if (req && gnt) begin
                if (flush || mq.size() == 0) begin
                    w1 = NOP;
                    if (nop_m < 16'hFFFF) nop_m++;
                end else begin
                    w1 = mq.pop_front();
                end
                e1.data = w1;
                e1.addr = addr;
                e1.due  = cyc + 1;
                exq.push_back(e1);
            end
            if (flush) mq.delete();
            else if (push_valid && rdy1) mq.push_back(push_data);
        end
    end

    always @(negedge clk) begin
        if (!rst3_n) begin
            mq3.delete();
            exq3.delete();
            chk("rst3_rvalid", rvalid3, 0);
            chk("rst3_data_addr", {rdata3, raddr3}, 64'd0);
            chk("rst3_state", {push_ready3, empty3, count3, nop_cnt3}, {1'b1, 1'b1, 5'd0, 16'd0});
        end else begin
            if (rvalid3) begin
                if (exq3.size() == 0) chk("l3_spurious_rvalid", 1, 0);
                else begin
                    e3 = exq3.pop_front();
                    chk("l3_rdata", rdata3, e3.data);
                    chk("l3_resp_addr", raddr3, e3.addr);
                    chk("l3_latency", cyc, e3.due);
                end
            end else if (exq3.size() > 0 && exq3[0].due <= cyc) begin
                chk("l3_missing_rvalid", 0, 1);
                void'(exq3.pop_front());
            end
            if (req3 && gnt3) begin
                e3.data = (mq3.size() == 0) ? NOP : mq3.pop_front();
                e3.addr = addr3;
                e3.due  = cyc + 3;
                exq3.push_back(e3);
            end
            if (push_valid3 && mq3.size() < DEPTH) mq3.push_back(push_data3);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        push_valid = 1'b1;
        push_data  = w;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [31:0] w);
        logic r;
        int   t = 0;
        push_valid = 1'b1;
        push_data  = w;
        do begin
            @(negedge clk);
            r = push_ready;
            tick();
            t++;
        end while (!r && t < 200);
        if (!r) chk("push_timeout", 0, 1);
        push_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        logic g;
        int   t = 0;
        req  = 1'b1;
        addr = a;
        do begin
            @(negedge clk);
            g = gnt;
            tick();
            t++;
        end while (!g && t < 200);
        if (!g) chk("gnt_timeout", 0, 1);
        req = 1'b0;
    endtask

    task automatic fetch3(input logic [31:0] a);
        logic g;
        int   t = 0;
        req3  = 1'b1;
        addr3 = a;
        do begin
            @(negedge clk);
            g = gnt3;
            tick();
            t++;
        end while (!g && t < 200);
        if (!g) chk("gnt3_timeout", 0, 1);
        req3 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        tick(2);

        // Two queued words returned in order to back-to-back fetches
        push_word(32'h0050_0093);
        push_word(32'h00A0_0113);
        fetch(32'h0);
        fetch(32'h4);
        tick(3);
        chk("t1_empty", empty, 1);

        // Empty queue answers with NOP
        fetch(32'h80);
        tick(2);
        chk("t2_nop_count", nop_cnt, 1);

        // Fill to DEPTH, overflow push ignored, pop frees a slot
        for (int i = 0; i < DEPTH; i++) push_word(32'h1000_0000 + i);
        chk("t3_ready_full", push_ready, 0);
        chk("t3_count_full", count, 16);
        push_word(32'hDEAD_BEEF);
        chk("t3_count_after_17th", count, 16);
        fetch(32'h200);
        chk("t3_ready_back", push_ready, 1);

        // Flush with a simultaneous fetch; the earlier fetch still completes
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h2000_0000 + i);
        fetch(32'h300);
        flush = 1'b1;
        fetch(32'h304);
        flush = 1'b0;
        chk("t4_count_flushed", count, 0);
        tick(2);

        // Push and fetch together: no bypass when empty, count steady when non-empty
        push_valid = 1'b1;
        push_data  = 32'hAAAA_0001;
        fetch(32'h400);
        push_valid = 1'b0;
`ifndef INSTR_FETCH_RESP_STALL_EN
        chk("t5_count_empty_case", count, 1);
`endif
        push_valid = 1'b1;
        push_data  = 32'hAAAA_0002;
        fetch(32'h404);
        push_valid = 1'b0;
`ifndef INSTR_FETCH_RESP_STALL_EN
        chk("t5_count_steady", count, 1);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(2);

        // LATENCY=3: three grants in a row, responses three cycles later
        for (int i = 0; i < 3; i++) begin
            push_valid3 = 1'b1;
            push_data3  = 32'h3000_0000 + i;
            tick();
        end
        push_valid3 = 1'b0;
        fetch3(32'h500);
        fetch3(32'h504);
        fetch3(32'h508);
        tick(6);
        chk("t6_l3_drained", exq3.size(), 0);

        // Reset right after the third grant kills every in-flight response
        for (int i = 0; i < 3; i++) begin
            push_valid3 = 1'b1;
            push_data3  = 32'h3100_0000 + i;
            tick();
        end
        push_valid3 = 1'b0;
        fetch3(32'h600);
        fetch3(32'h604);
        fetch3(32'h608);
        rst3_n = 1'b0;
        #1;
        chk("t6_rst_rvalid_now", rvalid3, 0);
        tick(4);
        rst3_n = 1'b1;
        tick(6);

        // 1000 words streamed through with random gaps on both sides
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    push_wait(32'($urandom));
                    if ($urandom_range(3) == 0) tick();
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    int t = 0;
                    while (mq.size() == 0 && t < 500) begin
                        tick();
                        t++;
                    end
                    fetch(32'h1_0000 + 32'(i) * 4);
                    if ($urandom_range(2) == 0) tick($urandom_range(3));
                end
            end
        join

        begin
            int t = 0;
            while ((exq.size() > 0 || exq3.size() > 0) && t < 50) begin
                tick();
                t++;
            end
        end
        chk("final_drain", exq.size(), 0);
        chk("final_drain3", exq3.size(), 0);
        chk("final_queue_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Synthesizable instruction-memory slave on the RISCY core's fetch port (instr_req/gnt/rvalid/addr/rdata).
- Testbench side pushes instruction words into an in-order queue. Each core fetch that is granted pops one word.
- The popped word returns on rdata after a fixed rvalid latency. The fetch address travels with it so monitors can pair PC and instruction.
- When the queue is empty, a fetch is served with a NOP.

Parameters:
- DEPTH, 16, instruction queue entries; power of 2, >=2.
- LATENCY, 1, cycles from grant to rvalid; >=1.
- NOP_INSTR, 32'h00000013, word returned when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- push_valid_i  in  1  testbench offers an instruction word
- push_data_i  in  32  instruction word
- push_ready_o  out  1  queue can accept (not full)
- flush_i  in  1  synchronous clear of the queue
- instr_req_i  in  1  core fetch request (core instr_req_o)
- instr_addr_i  in  32  fetch address (core instr_addr_o)
- instr_gnt_o  out  1  grant to core
- instr_rvalid_o  out  1  response valid to core
- instr_rdata_o  out  32  response instruction
- resp_addr_o  out  32  address belonging to the current rvalid beat
- fifo_count_o  out  $clog2(DEPTH)+1  queue occupancy
- empty_o  out  1  queue empty
- nop_count_o  out  16  NOP responses served, saturating

Behaviour:
- Reset (async, rst_ni=0):
  - Queue empty; pointers and count 0.
  - Delay line cleared.
  - instr_rvalid_o=0, instr_rdata_o=0, resp_addr_o=0, nop_count_o=0.
  - push_ready_o=1, empty_o=1, instr_gnt_o=0.
  - Reset mid-operation discards queued words and in-flight responses; no rvalid follows for any grant issued before reset.
- Grant:
  - instr_gnt_o = instr_req_i, combinational, no wait states in the base build.
  - A fetch is accepted on any posedge with req&&gnt.
- Pop:
  - On acceptance, if the queue is non-empty, pop the head. Otherwise select NOP_INSTR and increment nop_count_o, saturating at 16'hFFFF.
  - Selected word and instr_addr_i enter stage 0 of a LATENCY-deep delay line (valid, data, addr).
- Response:
  - instr_rvalid_o, instr_rdata_o and resp_addr_o are the registered outputs of the last delay stage.
  - rvalid asserts exactly LATENCY cycles after the accepting edge.
  - Back-to-back grants give back-to-back rvalids in order.
  - instr_rdata_o and resp_addr_o read 0 whenever rvalid=0.
- Push:
  - Word is written on a posedge with push_valid_i && push_ready_o.
  - push_ready_o = !full, where full means count==DEPTH.
- Simultaneous push and pop:
  - Non-empty and not full: both occur, count unchanged.
  - Full: push_ready_o=0, so only the pop occurs.
  - Empty: no bypass. The fetch gets NOP_INSTR, the pushed word is stored, and count becomes 1.
- Pointers wrap modulo DEPTH. fifo_count_o ranges 0..DEPTH.
- Flush:
  - flush_i=1 zeroes pointers and count at the next edge and has priority over push and pop in that cycle.
  - A fetch accepted in the flush cycle is served NOP_INSTR.
  - Entries already in the delay line still complete.
- empty_o = (count==0).

Optional Feature:
- Macro: INSTR_FETCH_RESP_STALL_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) steps every cycle.
  - instr_gnt_o = instr_req_i && !lfsr[0].
  - The core must hold req/addr until granted.
  - Pop and NOP counting happen only on actual acceptance.
- Undefined: no LFSR; grant is always immediate.

Decomposition:
- Shared package instr_fetch_resp_pkg holds:
  - NOP_INSTR_DEFAULT constant;
  - LFSR seed and tap mask constants;
  - typedef struct resp_beat_t {logic valid; logic [31:0] data; logic [31:0] addr;} for the delay line.
- One sub-module is natural: instr_fetch_fifo, a parameterized sync FIFO with push, pop, flush and count.
- Grant logic, NOP selection, delay line and counters live in the top.

Test Plan:
- Push 32'h00500093, 32'h00A00113. Hold req with addr 0x0 then 0x4, LATENCY=1 → rvalid on consecutive cycles: (0x00500093, addr 0x0), then (0x00A00113, addr 0x4); empty_o=1 after.
- Empty queue, one fetch at 0x80 → rdata=32'h00000013, resp_addr=0x80, nop_count_o=1.
- Push 16 words → push_ready_o=0, fifo_count_o=16. Push attempt of a 17th word is ignored. Next fetch returns word 0 and push_ready_o returns to 1.
- LATENCY=3, grants at cycles 10,11,12 → rvalid at 13,14,15 in push order. Assert rst_ni=0 at cycle 12 → no rvalid at 13–15, all outputs 0.
- Queue holds 4 words, flush_i with simultaneous fetch → that fetch returns NOP, fifo_count_o=0 next cycle, the in-flight prior response still arrives.
- With INSTR_FETCH_RESP_STALL_EN, 1000 fetches of 1000 pushed words → every word returned exactly once in order, with no rvalid lacking a prior grant.
